// File: rtl/mem_access_pkg.sv
// Shared encodings and lane helpers for the memory-access stage.
// Lanes are little-endian within the low 32 bits of a memory word.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_RSVD = 2'b10,
        SZ_WORD = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam int LANE_BYTES = 4;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lane[0];
            SZ_WORD: return lane != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [LANE_BYTES-1:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 4'b0001 << lane;
            SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Returns {sign, value}: the caller widens the sign bit to the data path width.
    function automatic logic [32:0] lane_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: return {{25{~uns & b[7]}}, b};
            SZ_HALF: return {{17{~uns & h[15]}}, h};
            default: return {~uns & word[31], word};
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_data_mem_bank.sv
// Word-organised data RAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module data_mem_bank #(
    parameter int NBITS     = 32,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic                 re_i,
    input  logic [NBITS/8-1:0]   be_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [NBITS-1:0]     wdata_i,
    output logic [NBITS-1:0]     rdata_o
);
    logic [NBITS-1:0] mem_q [2**ADDR_BITS];
    logic [NBITS-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < NBITS / 8; b++) begin
                if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory-access stage: byte/half/word loads and stores with wait-state
// latency, misalignment detection and a registered MEM/WB output.
module mem_access_stage
    import mem_access_pkg::*;
#(
    parameter int NBITS     = 32,
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 1,
    parameter int REG_BITS  = 5
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_rd_en,
    input  logic                i_wr_en,
    input  logic [1:0]          i_size,
    input  logic                i_unsigned,
    input  logic [NBITS-1:0]    i_eff_addr,
    input  logic [NBITS-1:0]    i_alu_rslt,
    input  logic                i_wb_en,
    input  logic [REG_BITS-1:0] i_wb_reg,
    output logic                o_valid,
    output logic [NBITS-1:0]    o_data,
    output logic                o_wb_en,
    output logic [REG_BITS-1:0] o_wb_reg,
    output logic                o_misalign
);
    localparam int         BE_W     = NBITS / 8;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e     state_q;
    logic [3:0] cnt_q;
    logic       fire_q;

    logic                accept, is_st, is_ld, is_mem, mis;
    logic [BE_W-1:0]     be;
    logic [NBITS-1:0]    wdata, rdata;
    logic [32:0]         ext;
    logic [NBITS-1:0]    data_d;
    logic                wb_en_d;

    logic                ld_q, st_q, mis_q, uns_q, wb_en_q;
    logic [1:0]          size_q, lane_q;
    logic [NBITS-1:0]    alu_q;
    logic [REG_BITS-1:0] wb_reg_q;

    logic                valid_q, out_wb_en_q, out_mis_q;
    logic [NBITS-1:0]    out_data_q;
    logic [REG_BITS-1:0] out_wb_reg_q;

    // Upper address bits alias onto the same words.
    logic unused_addr_hi;
    assign unused_addr_hi = ^i_eff_addr[NBITS-1:ADDR_BITS+2];

    assign o_ready = (state_q == ST_IDLE);
    assign accept  = i_valid & o_ready;
    assign is_st   = i_wr_en;
    assign is_ld   = i_rd_en & ~i_wr_en;
    assign is_mem  = is_st | is_ld;
    assign mis     = is_mem & misaligned(i_size, i_eff_addr[1:0]);

    always_comb begin
        wdata = '0;
        case (i_size)
            SZ_BYTE: wdata[31:0] = {4{i_alu_rslt[7:0]}};
            SZ_HALF: wdata[31:0] = {2{i_alu_rslt[15:0]}};
            default: wdata[31:0] = i_alu_rslt[31:0];
        endcase
        be = '0;
        be[LANE_BYTES-1:0] = lane_mask(i_size, i_eff_addr[1:0]);
    end

    data_mem_bank #(.NBITS(NBITS), .ADDR_BITS(ADDR_BITS)) u_mem (
        .clk_i   (i_clk),
        .we_i    (accept & is_st & ~mis),
        .re_i    (accept & is_ld & ~mis),
        .be_i    (be),
        .addr_i  (i_eff_addr[ADDR_BITS+1:2]),
        .wdata_i (wdata),
        .rdata_o (rdata)
    );

    // fire_q marks the op whose result is registered on the following edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fire_q  <= 1'b0;
        end else begin
            fire_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_mem && LATENCY > 1) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_INIT;
                        end else begin
                            fire_q <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        fire_q  <= 1'b1;
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ld_q     <= 1'b0;
            st_q     <= 1'b0;
            mis_q    <= 1'b0;
            uns_q    <= 1'b0;
            wb_en_q  <= 1'b0;
            size_q   <= '0;
            lane_q   <= '0;
            alu_q    <= '0;
            wb_reg_q <= '0;
        end else if (accept) begin
            ld_q     <= is_ld;
            st_q     <= is_st;
            mis_q    <= mis;
            uns_q    <= i_unsigned;
            wb_en_q  <= i_wb_en;
            size_q   <= i_size;
            lane_q   <= i_eff_addr[1:0];
            alu_q    <= i_alu_rslt;
            wb_reg_q <= i_wb_reg;
        end
    end

    assign ext = lane_extend(rdata[31:0], size_q, lane_q, uns_q);

    always_comb begin
        data_d  = alu_q;
        wb_en_d = wb_en_q & ~mis_q & ~st_q;
        if (mis_q || st_q) data_d = '0;
        else if (ld_q)     data_d = NBITS'($signed(ext));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q      <= 1'b0;
            out_data_q   <= '0;
            out_wb_en_q  <= 1'b0;
            out_wb_reg_q <= '0;
            out_mis_q    <= 1'b0;
        end else begin
            valid_q <= fire_q;
            if (fire_q) begin
                out_data_q   <= data_d;
                out_wb_en_q  <= wb_en_d;
                out_wb_reg_q <= wb_reg_q;
                out_mis_q    <= mis_q;
            end
        end
    end

    assign o_valid    = valid_q;
    assign o_data     = out_data_q;
    assign o_wb_en    = out_wb_en_q;
    assign o_wb_reg   = out_wb_reg_q;
    assign o_misalign = out_mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench: two stage instances (LATENCY 1 and 4) driven by directed and
// random requests, checked against a byte-level memory model.
module tb_mem_access_stage;

    typedef struct {
        logic [31:0] data;
        logic        wben;
        logic [4:0]  wreg;
        logic        mis;
        int          edge_n;
    } exp_t;

    localparam logic [1:0] SB = 2'b00, SH = 2'b01, SR = 2'b10, SW = 2'b11;

    logic clk = 1'b0;
    logic rst;
    logic [1:0]       valid, rdy, rd, wr, uns, wben, ovalid, owben, omis;
    logic [1:0][1:0]  size;
    logic [1:0][31:0] addr, alu, odata;
    logic [1:0][4:0]  wreg, owreg;

    int checks = 0, failures = 0, cyc = 0;
    exp_t q0[$], q1[$];
    logic [31:0] mdl [2][16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_stage #(.NBITS(32), .ADDR_BITS(10), .LATENCY(1), .REG_BITS(5)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid[0]), .o_ready(rdy[0]),
        .i_rd_en(rd[0]), .i_wr_en(wr[0]), .i_size(size[0]), .i_unsigned(uns[0]),
        .i_eff_addr(addr[0]), .i_alu_rslt(alu[0]), .i_wb_en(wben[0]), .i_wb_reg(wreg[0]),
        .o_valid(ovalid[0]), .o_data(odata[0]), .o_wb_en(owben[0]), .o_wb_reg(owreg[0]),
        .o_misalign(omis[0]));

    mem_access_stage #(.NBITS(32), .ADDR_BITS(10), .LATENCY(4), .REG_BITS(5)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid[1]), .o_ready(rdy[1]),
        .i_rd_en(rd[1]), .i_wr_en(wr[1]), .i_size(size[1]), .i_unsigned(uns[1]),
        .i_eff_addr(addr[1]), .i_alu_rslt(alu[1]), .i_wb_en(wben[1]), .i_wb_reg(wreg[1]),
        .o_valid(ovalid[1]), .o_data(odata[1]), .o_wb_en(owben[1]), .o_wb_reg(owreg[1]),
        .o_misalign(omis[1]));

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: memory as 16 words of bytes; addresses map to word addr[5:2].
    function automatic exp_t model(int d, logic r, logic w, logic [1:0] sz, logic u,
                                   logic [31:0] a, logic [31:0] al, logic we_,
                                   logic [4:0] rg, int edge_n);
        exp_t e;
        int nb, wi, ln;
        logic [31:0] v;
        nb = (sz == SB) ? 1 : (sz == SH) ? 2 : 4;
        wi = int'(a[5:2]);
        ln = int'(a[1:0]);
        e.edge_n = edge_n; e.wreg = rg; e.data = '0; e.wben = 1'b0; e.mis = 1'b0;
        if (!r && !w) begin
            e.data = al; e.wben = we_;
            return e;
        end
        e.mis = (sz == SR) || (ln % nb != 0);
        if (e.mis) return e;
        if (w) begin
            for (int i = 0; i < nb; i++) mdl[d][wi][8*(ln+i) +: 8] = al[8*i +: 8];
            return e;
        end
        v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl[d][wi][8*(ln+i) +: 8];
        if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        e.data = v; e.wben = we_;
        return e;
    endfunction

    task automatic issue(int d, logic r, logic w, logic [1:0] sz, logic u, logic [31:0] a,
                         logic [31:0] al, logic we_, logic [4:0] rg);
        int n = 0;
        exp_t e;
        @(negedge clk);
        rd[d] = r; wr[d] = w; size[d] = sz; uns[d] = u; addr[d] = a; alu[d] = al;
        wben[d] = we_; wreg[d] = rg; valid[d] = 1'b1;
        while (!rdy[d] && n < 20) begin @(negedge clk); n++; end
        if (!rdy[d]) begin
            checks++; failures++;
            $display("FAIL ready_timeout dut%0d: o_ready=%b, expected 1", d, rdy[d]);
            valid[d] = 1'b0;
            return;
        end
        e = model(d, r, w, sz, u, a, al, we_, rg, cyc + 1 + (((r || w) && d == 1) ? 4 : 1));
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        @(posedge clk); #1;
        valid[d] = 1'b0;
    endtask

    task automatic rand_op(int d);
        int k, s;
        logic r, w;
        logic [1:0] sz;
        k = $urandom_range(0, 9);
        s = $urandom_range(0, 7);
        r = (k >= 5);
        w = (k >= 3 && k <= 5);
        sz = (s <= 2) ? SB : (s <= 4) ? SH : (s <= 6) ? SW : SR;
        issue(d, r, w, sz, 1'($urandom), {20'($urandom), 6'd0, 6'($urandom)}, $urandom,
              1'($urandom), 5'($urandom));
    endtask

    task automatic chk_rst(int d);
        chk($sformatf("rst_valid%0d", d), 32'(ovalid[d]), 32'd0);
        chk($sformatf("rst_data%0d", d), odata[d], 32'd0);
        chk($sformatf("rst_wben%0d", d), 32'(owben[d]), 32'd0);
        chk($sformatf("rst_wreg%0d", d), 32'(owreg[d]), 32'd0);
        chk($sformatf("rst_mis%0d", d), 32'(omis[d]), 32'd0);
        chk($sformatf("rst_ready%0d", d), 32'(rdy[d]), 32'd1);
    endtask

    // Monitor: pops the scoreboard whenever a stage presents a result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("l1_ready_high", 32'(rdy[0]), 32'd1);
            for (int d = 0; d < 2; d++) begin
                if (ovalid[d]) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        checks++; failures++;
                        $display("FAIL unexpected_valid dut%0d: o_valid=1, expected 0", d);
                    end else begin
                        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
                        chk($sformatf("dut%0d_latency", d), 32'(cyc), 32'(e.edge_n));
                        chk($sformatf("dut%0d_data", d), odata[d], e.data);
                        chk($sformatf("dut%0d_wb_en", d), 32'(owben[d]), 32'(e.wben));
                        chk($sformatf("dut%0d_misalign", d), 32'(omis[d]), 32'(e.mis));
                        if (e.wben) chk($sformatf("dut%0d_wb_reg", d), 32'(owreg[d]), 32'(e.wreg));
                    end
                end else if ((d == 0 && q0.size() > 0 && q0[0].edge_n <= cyc) ||
                             (d == 1 && q1.size() > 0 && q1[0].edge_n <= cyc)) begin
                    checks++; failures++;
                    $display("FAIL missing_valid dut%0d: o_valid=0, expected 1 at edge %0d", d,
                             (d == 0) ? q0[0].edge_n : q1[0].edge_n);
                    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1; valid = '0; rd = '0; wr = '0; size = '0; uns = '0;
        addr = '0; alu = '0; wben = '0; wreg = '0;
        repeat (2) @(negedge clk);
        chk_rst(0); chk_rst(1);
        rst = 1'b0;

        fork
            for (int i = 0; i < 16; i++) issue(0, 1'b0, 1'b1, SW, 1'b0, 32'(i*4), $urandom, 1'b0, 5'd0);
            for (int i = 0; i < 16; i++) issue(1, 1'b0, 1'b1, SW, 1'b0, 32'(i*4), $urandom, 1'b0, 5'd0);
        join

        // LATENCY=1 directed sequence.
        issue(0, 1'b0, 1'b1, SW, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 5'd3);
        issue(0, 1'b1, 1'b0, SW, 1'b0, 32'h10, 32'h0, 1'b1, 5'd4);
        issue(0, 1'b1, 1'b0, SB, 1'b0, 32'h13, 32'h0, 1'b1, 5'd5);
        issue(0, 1'b1, 1'b0, SB, 1'b1, 32'h13, 32'h0, 1'b1, 5'd6);
        issue(0, 1'b1, 1'b0, SH, 1'b0, 32'h12, 32'h0, 1'b1, 5'd7);
        issue(0, 1'b0, 1'b1, SB, 1'b0, 32'h11, 32'h55, 1'b0, 5'd0);
        issue(0, 1'b1, 1'b0, SW, 1'b0, 32'h10, 32'h0, 1'b1, 5'd8);
        issue(0, 1'b1, 1'b0, SH, 1'b0, 32'h11, 32'h0, 1'b1, 5'd9);
        issue(0, 1'b1, 1'b0, SW, 1'b0, 32'h12, 32'h0, 1'b1, 5'd10);
        issue(0, 1'b1, 1'b0, SW, 1'b0, 32'h10, 32'h0, 1'b1, 5'd11);
        issue(0, 1'b1, 1'b0, SW, 1'b1, 32'hABC00010, 32'h0, 1'b1, 5'd12);

        // LATENCY=4: ready stays low three cycles after a memory accept.
        issue(1, 1'b1, 1'b0, SW, 1'b0, 32'h10, 32'h0, 1'b1, 5'd12);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("l4_ready_wait", 32'(rdy[1]), (i < 3) ? 32'd0 : 32'd1);
        end
        issue(1, 1'b1, 1'b0, SH, 1'b1, 32'h16, 32'h0, 1'b1, 5'd13);
        issue(1, 1'b0, 1'b0, SW, 1'b0, 32'h0, 32'hCAFE0001, 1'b1, 5'd17);
        issue(1, 1'b0, 1'b0, SW, 1'b0, 32'h0, 32'h0BAD0002, 1'b1, 5'd18);

        // Reset while a load is waiting.
        issue(1, 1'b0, 1'b1, SW, 1'b0, 32'h20, 32'h12345678, 1'b0, 5'd0);
        issue(1, 1'b1, 1'b0, SW, 1'b0, 32'h24, 32'h0, 1'b1, 5'd1);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        chk_rst(0); chk_rst(1);
        q1.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_valid", 32'(ovalid), 32'd0);
        end
        rst = 1'b0;
        issue(1, 1'b1, 1'b0, SW, 1'b0, 32'h20, 32'h0, 1'b1, 5'd2);

        fork
            for (int i = 0; i < 120; i++) rand_op(0);
            for (int i = 0; i < 120; i++) rand_op(1);
        join

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised pipeline memory-access stage: owns a byte-enabled word-organised data memory, performs byte/half/word loads and stores with sign or zero extension, and adds configurable wait-state latency with a valid/ready handshake, misalignment detection and a registered MEM/WB output. Sits between the execute stage (ALU result, effective address) and write-back. Successor to the single-cycle, fixed-width memory-access wrapper.

## Interface
- NBITS, 32: data path width; multiple of 8, ≥ 32.
- ADDR_BITS, 10: word-address bits; memory depth 2^ADDR_BITS words.
- LATENCY, 1: memory-op latency in cycles, 1..8.
- REG_BITS, 5: write-back register index width.
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  request present.
- o_ready  out  1  stage can accept; transfer = i_valid & o_ready.
- i_rd_en / i_wr_en  in  1  load / store (both low = pass-through op; both high = store).
- i_size  in  2  00 byte, 01 half, 11 word, 10 reserved.
- i_unsigned  in  1  zero-extend loads when high.
- i_eff_addr  in  NBITS  byte address.
- i_alu_rslt  in  NBITS  pass-through result; store data (low bytes) for stores.
- i_wb_en  in  1, i_wb_reg  in  REG_BITS  write-back tags.
- o_valid  out  1  one-cycle result pulse.
- o_data  out  NBITS  load data or ALU result.
- o_wb_en  out  1, o_wb_reg  out  REG_BITS  write-back tags.
- o_misalign  out  1  fault flag, qualified by o_valid.

## Operation
- Lanes little-endian: byte lane = addr[1:0]; half lane = addr[1]; word index = addr[ADDR_BITS+1:2], upper address bits ignored (aliasing).
- Misaligned: half with addr[0]=1, word with addr[1:0]≠0, or size 10. Misaligned access: no memory write, o_data=0, o_wb_en=0, o_misalign=1.
- Store: write of byte lanes at the accept edge; o_data=0, o_wb_en=0.
- Load: memory read at the accept edge; selected lane extended per i_unsigned; o_wb_en=i_wb_en.
- Pass-through: o_data=i_alu_rslt, o_wb_en=i_wb_en, no memory access.
- Request fields captured into internal registers at accept; upstream need not hold them.
- FSM: IDLE (o_ready=1) → accept memory op with LATENCY>1 → WAIT (o_ready=0, counter loaded LATENCY-1, decrements) → counter 1: o_valid next edge, return IDLE. Pass-through ops and LATENCY=1 never leave IDLE.
- Store then load to same word: load observes stored bytes (write precedes read by ≥1 edge).
- Reset mid-WAIT: pending op dropped, no o_valid; memory contents not reset (writes already committed remain).

## Timing
- Reset values: o_valid=0, o_data=0, o_wb_en=0, o_wb_reg=0, o_misalign=0, o_ready=1, state IDLE, counter 0.
- Accept at edge k: pass-through → o_valid high in cycle after edge k+1... i.e. registered at k+1 for one cycle; memory op → o_valid registered at edge k+LATENCY.
- o_ready low for cycles between edges k+1 and k+LATENCY; next accept possible at edge k+LATENCY (throughput one memory op per LATENCY cycles; pass-through one per cycle).
- o_data/o_wb_* valid only while o_valid=1; hold last value otherwise.
- o_ready is registered (state-derived), no combinational path from i_valid.

## Structure
- Package mem_access_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum (ST_IDLE, ST_WAIT), lane-extend function.
- Sub-module data_mem_bank: 2^ADDR_BITS × NBITS RAM, per-byte write enable, synchronous read, no reset.
- Top holds FSM, latency counter, request capture, lane select/extend, output register.

## Test plan
- LATENCY=1: store word 0xDEADBEEF @0x10, then load word @0x10 → o_valid next cycle, o_data=0xDEADBEEF, o_ready never drops.
- Load byte @0x13 signed → 0xFFFFFFDE; unsigned → 0x000000DE; load half @0x12 signed → 0xFFFFDEAD.
- Store byte 0x55 @0x11 then load word @0x10 → 0xDEAD55EF.
- Load half @0x11 and word @0x12 → o_misalign=1, o_data=0, o_wb_en=0; subsequent word load @0x10 unchanged.
- LATENCY=4: load accepted edge k → o_ready low 3 cycles, o_valid at k+4; back-to-back pass-through after returns in 1 cycle with o_data=i_alu_rslt, o_wb_reg forwarded.
- LATENCY=4: assert i_rst in WAIT → outputs at reset values immediately, no o_valid; prior stores still readable after release.
